// File: rtl/mem_if_pkg.sv
// mem_if_pkg: shared defaults, FSM state type and write-mode constants for block_mem_responder
package mem_if_pkg;
  localparam int DEF_ADDR_W = 4;
  localparam int DEF_DATA_W = 4;
  localparam int WM_READ_FIRST = 0;
  localparam int WM_WRITE_FIRST = 1;
  typedef enum logic {ST_INIT, ST_READY} state_t;
endpackage

// File: rtl/mem_rd_pipe.sv
// mem_rd_pipe: READ_LATENCY-deep {valid,data} shift register driving douta/dout_valid
//  in: clk, rst_n (async active-low clear), in_valid, in_data
//  out: douta (holds between valid strobes), dout_valid
module mem_rd_pipe #(
  parameter int DATA_W = 4,
  parameter int READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic [DATA_W-1:0] douta,
  output logic              dout_valid
);
  logic [READ_LATENCY-1:0] v;
  logic [DATA_W-1:0] d [READ_LATENCY];
  // data stages only load behind a valid entry, so the last stage holds douta between strobes
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      v <= '0;
      for (int i = 0; i < READ_LATENCY; i++) d[i] <= '0;
    end else begin
      v[0] <= in_valid;
      if (in_valid) d[0] <= in_data;
      for (int i = 1; i < READ_LATENCY; i++) begin
        v[i] <= v[i-1];
        if (v[i-1]) d[i] <= d[i-1];
      end
    end
  assign douta = d[READ_LATENCY-1];
  assign dout_valid = v[READ_LATENCY-1];
endmodule

// File: rtl/block_mem_responder.sv
// block_mem_responder: single-port synchronous memory with init sweep and fixed-latency read return
//  in: clk, rst_n (async active-low), ena, wea, addra, dina
//  out: douta, dout_valid (one pulse per served request), init_busy (sweep in progress)
module block_mem_responder
  import mem_if_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int READ_LATENCY = 1,
  parameter int WRITE_MODE = WM_READ_FIRST,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              wea,
  input  logic [ADDR_W-1:0] addra,
  input  logic [DATA_W-1:0] dina,
  output logic [DATA_W-1:0] douta,
  output logic              dout_valid,
  output logic              init_busy
);
  logic [DATA_W-1:0] mem [2**ADDR_W];
  state_t state;
  logic [ADDR_W-1:0] ptr;
  logic req;
  logic [DATA_W-1:0] rd_data;
  assign req = state == ST_READY && ena;
  assign rd_data = (wea && WRITE_MODE == WM_WRITE_FIRST) ? dina : mem[addra];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= ST_INIT;
      ptr <= '0;
      init_busy <= 1'b1;
    end else if (state == ST_INIT) begin
      ptr <= ptr + 1'b1;
      if (ptr == '1) begin
        state <= ST_READY;
        init_busy <= 1'b0;
      end
    end
  // array has no reset; the sweep overwrites every location after each reset
  always_ff @(posedge clk)
    if (state == ST_INIT) mem[ptr] <= INIT_VAL;
    else if (req && wea) mem[addra] <= dina;
  mem_rd_pipe #(.DATA_W(DATA_W), .READ_LATENCY(READ_LATENCY)) u_pipe (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(req),
    .in_data(rd_data),
    .douta(douta),
    .dout_valid(dout_valid)
  );
endmodule

// File: tb/tb_block_mem_responder.sv
// tb_block_mem_responder: three responder configurations driven in parallel against a schedule-based model
module tb_block_mem_responder;
  logic clk = 0, rst_n = 1, ena = 0, wea = 0;
  logic [3:0] addra = 0, dina = 0;
  logic [3:0] douta [3];
  logic dv [3], ib [3];
  int rl [3] = '{1, 1, 3};
  int wm [3] = '{0, 1, 0};
  int n_cmp = 0, n_err = 0;
  int mem_m [16];
  int cnt, e;
  int exp_d [3];
  bit sched_v [3][8];
  int sched_d [3][8];
  bit exp_v [3];
  always #5 clk = ~clk;
  block_mem_responder #(.READ_LATENCY(1), .WRITE_MODE(0)) dut0 (.clk(clk), .rst_n(rst_n), .ena(ena), .wea(wea), .addra(addra), .dina(dina), .douta(douta[0]), .dout_valid(dv[0]), .init_busy(ib[0]));
  block_mem_responder #(.READ_LATENCY(1), .WRITE_MODE(1)) dut1 (.clk(clk), .rst_n(rst_n), .ena(ena), .wea(wea), .addra(addra), .dina(dina), .douta(douta[1]), .dout_valid(dv[1]), .init_busy(ib[1]));
  block_mem_responder #(.READ_LATENCY(3), .WRITE_MODE(0)) dut2 (.clk(clk), .rst_n(rst_n), .ena(ena), .wea(wea), .addra(addra), .dina(dina), .douta(douta[2]), .dout_valid(dv[2]), .init_busy(ib[2]));
  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask
  task automatic check_all();
    for (int k = 0; k < 3; k++) begin
      check($sformatf("init_busy%0d", k), int'(ib[k]), int'(cnt < 16));
      check($sformatf("dout_valid%0d", k), int'(dv[k]), int'(exp_v[k]));
      check($sformatf("douta%0d", k), int'(douta[k]), exp_d[k]);
    end
  endtask
  task automatic model_reset();
    cnt = 0;
    e = 0;
    for (int k = 0; k < 3; k++) begin
      exp_d[k] = 0;
      exp_v[k] = 0;
      for (int s = 0; s < 8; s++) sched_v[k][s] = 0;
    end
  endtask
  // a served request at edge e is due at edge e+RL-1 in each configuration
  task automatic model_edge(input bit en, input bit we, input int a, input int d);
    int slot;
    e++;
    if (cnt < 16) begin
      mem_m[cnt] = 0;
      cnt++;
    end else if (en) begin
      for (int k = 0; k < 3; k++) begin
        slot = (e + rl[k] - 1) % 8;
        sched_v[k][slot] = 1;
        sched_d[k][slot] = (we && wm[k] == 1) ? d % 16 : mem_m[a % 16];
      end
      if (we) mem_m[a % 16] = d % 16;
    end
    for (int k = 0; k < 3; k++) begin
      slot = e % 8;
      exp_v[k] = sched_v[k][slot];
      if (exp_v[k]) exp_d[k] = sched_d[k][slot];
      sched_v[k][slot] = 0;
    end
  endtask
  task automatic step(input bit en, input bit we, input int a, input int d);
    ena = en;
    wea = we;
    addra = a[3:0];
    dina = d[3:0];
    @(posedge clk);
    model_edge(en, we, a, d);
    #1 check_all();
    @(negedge clk);
  endtask
  task automatic do_reset();
    rst_n = 0;
    ena = 0;
    wea = 0;
    model_reset();
    #1 check_all();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
  endtask
  initial begin
    #1;
    do_reset();
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(1, 1, 2, 15);
    repeat (13) step(0, 0, 0, 0);
    step(1, 0, 5, 0);
    step(0, 0, 0, 0);
    step(1, 1, 3, 10);
    step(1, 0, 3, 0);
    step(1, 1, 9, 2);
    step(1, 1, 9, 7);
    step(1, 0, 9, 0);
    step(1, 0, 2, 0);
    step(1, 0, 14, 0);
    step(1, 0, 15, 0);
    step(1, 0, 16, 0);
    step(1, 0, 1, 0);
    repeat (5) step(0, 0, 0, 0);
    repeat (300) step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), int'($urandom_range(0, 31)), int'($urandom_range(0, 15)));
    step(1, 0, 3, 0);
    step(1, 0, 4, 0);
    #2;
    do_reset();
    repeat (20) step(0, 0, 0, 0);
    repeat (40) step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), int'($urandom_range(0, 31)), int'($urandom_range(0, 15)));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
